// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM modes with wrap pulses,
// programmed through a single-cycle write port and phase-aligned by a global sync.
module led_pattern_gen #(
  parameter int N_CH   = 8,
  parameter int PER_W  = 26,
  parameter int DUTY_W = 8,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [DUTY_W-1:0] cfg_duty,
  input  logic              sync,
  output logic [N_CH-1:0]   LED,
  output logic [N_CH-1:0]   wrap
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [DUTY_W-1:0] fc_q;
  logic              fc_last;
  logic [N_CH-1:0]   led_d;
  logic [N_CH-1:0]   wrap_d;

  assign fc_last = (fc_q == '1);

  // Shared PWM frame counter; sync realigns it with the blink phase counters.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q <= '0;
    end else if (sync) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_q + DUTY_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    mode_e             mode_q;
    logic [PER_W-1:0]  period_q;
    logic [DUTY_W-1:0] duty_q;
    logic [PER_W-1:0]  cnt_q;
    logic [PER_W-1:0]  cnt_d;
    logic [PER_W-1:0]  last;
    logic [PER_W:0]    half;
    logic              wr;
    logic              running;
    logic              at_last;

    // Indices at or above N_CH never match any channel, so such writes fall away.
    assign wr      = cfg_we && (cfg_ch == CH_W'(i));
    assign running = (mode_q == MODE_BLINK) && (period_q != '0);
    assign last    = period_q - PER_W'(1);
    assign at_last = (cnt_q == last);
    // One extra bit keeps ceil(P/2) exact at the maximum period.
    assign half    = ({1'b0, period_q} + (PER_W + 1)'(1)) >> 1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      cnt_d = '0;
      if (!wr && !sync && running && !at_last) begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end

    always_comb begin
      led_d[i]  = 1'b0;
      wrap_d[i] = 1'b0;
      unique case (mode_q)
        MODE_OFF: led_d[i] = 1'b0;
        MODE_ON:  led_d[i] = 1'b1;
        MODE_BLINK: begin
          led_d[i]  = running && ({1'b0, cnt_q} < half);
          wrap_d[i] = running && at_last;
        end
        MODE_PWM: begin
          led_d[i]  = (fc_q < duty_q);
          wrap_d[i] = fc_last;
        end
        default: ;
      endcase
    end

    // NOTE: configuration registers are reset too, since a reset must forget all programming.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q   <= MODE_OFF;
        period_q <= '0;
        duty_q   <= '0;
        cnt_q    <= '0;
      end else begin
        if (wr) begin
          mode_q   <= mode_e'(cfg_mode);
          period_q <= cfg_period;
          duty_q   <= cfg_duty;
        end
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LED  <= '0;
      wrap <= '0;
    end else begin
      LED  <= led_d;
      wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen with six channels, so that
// channel indices 6 and 7 are out of range.
module tb_led_pattern_gen;
  localparam int NC     = 6;
  localparam int PER_W  = 26;
  localparam int DUTY_W = 8;
  localparam int CH_W   = 3;

  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_PWM = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [PER_W-1:0]  cfg_period;
  logic [DUTY_W-1:0] cfg_duty;
  logic              sync;
  logic [NC-1:0]     LED;
  logic [NC-1:0]     wrap;

  int errors = 0;
  int checks = 0;

  led_pattern_gen #(.N_CH(NC), .PER_W(PER_W), .DUTY_W(DUTY_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .sync(sync), .LED(LED), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The write lands on the next edge; the sample after it still shows the old LED.
  task automatic write_cfg(input int ch, input logic [1:0] mode, input int period,
                           input int duty, input logic with_sync);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_mode   = mode;
    cfg_period = PER_W'(period);
    cfg_duty   = DUTY_W'(duty);
    sync       = with_sync;
    tick();
    cfg_we = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (LED !== '0 || wrap !== '0) begin
      errors++;
      $display("FAIL reset_hold: LED=%b wrap=%b expected 000000/000000", LED, wrap);
    end
    rst = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      checks++;
      if (LED !== '0 || wrap !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: LED=%b wrap=%b expected 000000/000000", j, LED, wrap);
      end
    end
  endtask

  task automatic test_blink_ch0();
    logic [NC-1:0] el, ew;
    write_cfg(0, M_BLINK, 10, 0, 1'b0);
    for (int j = 0; j < 30; j++) begin
      tick();
      el = '0; ew = '0;
      el[0] = (j % 10) < 5;
      ew[0] = (j % 10) == 9;
      checks++;
      if (LED !== el || wrap !== ew) begin
        errors++;
        $display("FAIL blink_p10 cyc %0d: LED=%b wrap=%b expected %b/%b", j, LED, wrap, el, ew);
      end
    end
    write_cfg(0, M_OFF, 0, 0, 1'b0);
  endtask

  task automatic test_blink_ch3();
    logic [NC-1:0] el, ew;
    write_cfg(3, M_BLINK, 7, 0, 1'b0);
    for (int j = 0; j < 21; j++) begin
      tick();
      el = '0; ew = '0;
      el[3] = (j % 7) < 4;
      ew[3] = (j % 7) == 6;
      checks++;
      if (LED !== el || wrap !== ew) begin
        errors++;
        $display("FAIL blink_p7 cyc %0d: LED=%b wrap=%b expected %b/%b", j, LED, wrap, el, ew);
      end
    end
    write_cfg(3, M_BLINK, 0, 0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (LED !== '0 || wrap !== '0) begin
        errors++;
        $display("FAIL blink_p0 cyc %0d: LED=%b wrap=%b expected 000000/000000", j, LED, wrap);
      end
    end
    write_cfg(3, M_BLINK, 1, 0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (LED !== 6'b001000 || wrap !== 6'b001000) begin
        errors++;
        $display("FAIL blink_p1 cyc %0d: LED=%b wrap=%b expected 001000/001000", j, LED, wrap);
      end
    end
    write_cfg(3, M_OFF, 0, 0, 1'b0);
  endtask

  task automatic test_pwm_ch5();
    int duties [3] = '{64, 0, 255};
    logic [NC-1:0] el, ew;
    foreach (duties[d]) begin
      // Sync with the write so the frame counter starts at 0 on that same edge.
      write_cfg(5, M_PWM, 0, duties[d], 1'b1);
      for (int j = 0; j < 512; j++) begin
        tick();
        el = '0; ew = '0;
        el[5] = (j % 256) < duties[d];
        ew[5] = (j % 256) == 255;
        checks++;
        if (LED !== el || wrap !== ew) begin
          errors++;
          $display("FAIL pwm_d%0d cyc %0d: LED=%b wrap=%b expected %b/%b",
                   duties[d], j, LED, wrap, el, ew);
        end
      end
    end
    write_cfg(5, M_OFF, 0, 0, 1'b0);
  endtask

  task automatic test_sync_align();
    logic [NC-1:0] el, ew;
    write_cfg(1, M_BLINK, 8, 0, 1'b0);
    tick();
    tick();
    write_cfg(2, M_BLINK, 8, 0, 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int j = 0; j < 24; j++) begin
      tick();
      el = '0; ew = '0;
      el[1] = (j % 8) < 4;  el[2] = el[1];
      ew[1] = (j % 8) == 7; ew[2] = ew[1];
      checks++;
      if (LED !== el || wrap !== ew) begin
        errors++;
        $display("FAIL sync_align cyc %0d: LED=%b wrap=%b expected %b/%b", j, LED, wrap, el, ew);
      end
    end
    write_cfg(1, M_BLINK, 4, 0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      tick();
      el = '0; ew = '0;
      el[1] = (j % 4) < 2;
      ew[1] = (j % 4) == 3;
      el[2] = (j % 8) < 4;
      ew[2] = (j % 8) == 7;
      checks++;
      if (LED !== el || wrap !== ew) begin
        errors++;
        $display("FAIL sync_with_write cyc %0d: LED=%b wrap=%b expected %b/%b",
                 j, LED, wrap, el, ew);
      end
    end
    write_cfg(1, M_OFF, 0, 0, 1'b0);
    write_cfg(2, M_OFF, 0, 0, 1'b0);
  endtask

  task automatic test_out_of_range();
    write_cfg(7, M_ON, 0, 0, 1'b0);
    write_cfg(6, M_ON, 0, 0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++;
      if (LED !== '0 || wrap !== '0) begin
        errors++;
        $display("FAIL out_of_range cyc %0d: LED=%b wrap=%b expected 000000/000000", j, LED, wrap);
      end
    end
    write_cfg(5, M_ON, 0, 0, 1'b0);
    checks++;
    if (LED !== '0) begin
      errors++;
      $display("FAIL on_latency: LED=%b expected 000000", LED);
    end
    tick();
    checks++;
    if (LED !== 6'b100000 || wrap !== '0) begin
      errors++;
      $display("FAIL on_ch5: LED=%b wrap=%b expected 100000/000000", LED, wrap);
    end
  endtask

  task automatic test_async_reset();
    logic [NC-1:0] el;
    write_cfg(0, M_BLINK, 10, 0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      el = 6'b100001;
      checks++;
      if (LED !== el) begin
        errors++;
        $display("FAIL pre_reset_blink cyc %0d: LED=%b expected %b", j, LED, el);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (LED !== '0 || wrap !== '0) begin
      errors++;
      $display("FAIL async_reset: LED=%b wrap=%b expected 000000/000000", LED, wrap);
    end
    #2 rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      checks++;
      if (LED !== '0 || wrap !== '0) begin
        errors++;
        $display("FAIL config_lost cyc %0d: LED=%b wrap=%b expected 000000/000000", j, LED, wrap);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = M_OFF;
    cfg_period = '0;
    cfg_duty   = '0;
    sync       = 1'b0;
    test_reset();
    test_blink_ch0();
    test_blink_ch3();
    test_pwm_ch5();
    test_sync_align();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver; next generation of the free-running-counter LED blinker. Each of N_CH channels has its own runtime-programmable mode (off, on, blink with programmable period, PWM dimming) and a wrap pulse. Sits between the board clock and the LED pins. A control block or test harness programs it through a single-cycle write port; a sync input phase-aligns all channels.

## Interface
- N_CH, 8, number of LED channels (1..32)
- PER_W, 26, width of blink period register, in clock cycles
- DUTY_W, 8, PWM resolution; PWM frame is 2^DUTY_W cycles
- CH_W, max(1, clog2(N_CH)), derived; width of cfg_ch

- clk  in  1  system clock (50 MHz on board)
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write strobe, one cycle per write
- cfg_ch  in  CH_W  channel index for write
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
- cfg_period  in  PER_W  blink period P in cycles
- cfg_duty  in  DUTY_W  PWM on-count D per frame
- sync  in  1  clears all phase counters
- LED  out  N_CH  registered LED drive, 1 = lit
- wrap  out  N_CH  registered one-cycle pulse per completed period/frame

## Operation
- One clock; reset is asynchronous and active-high.
- Per-channel state: mode, period, duty, phase counter cnt (PER_W bits). Shared PWM frame counter fc (DUTY_W bits, free-running, wraps 2^DUTY_W-1 -> 0).
- rst: all mode/period/duty/cnt/fc = 0; LED = 0; wrap = 0; takes effect immediately, no clock edge needed.
- Write: cfg_we with cfg_ch < N_CH loads mode/period/duty into that channel and clears its cnt to 0 at the same edge. cfg_ch >= N_CH: write ignored, no state change.
- Channel running = (mode == BLINK) and (period != 0). Running: cnt increments each cycle; cnt == period-1 -> cnt = 0. Not running: cnt held 0.
- sync: at the edge, all cnt and fc cleared to 0. sync plus cfg_we in the same cycle: both apply; the written channel gets new config and cnt = 0.
- LED[i] next value, from current-cycle state:
  - OFF: 0. ON: 1.
  - BLINK: period 0 -> 0; else 1 when cnt < ceil(P/2), computed as (P+1)>>1 in PER_W+1 bits, no overflow at P = 2^PER_W-1.
  - PWM: 1 when fc < duty (unsigned). D=0 -> always 0; max D -> lit 2^DUTY_W-1 of 2^DUTY_W cycles.
- wrap[i] next value: BLINK running and cnt == period-1; PWM and fc == 2^DUTY_W-1; otherwise 0.

## Timing
- Write at edge k: new config and cnt = 0 hold from edge k. LED reflects the new mode from edge k+1; 1-cycle latency.
- BLINK period P: LED high ceil(P/2) cycles, then low floor(P/2) cycles, repeating every P cycles. First high cycle starts at edge k+1.
- P = 1: LED constantly 1; wrap high every cycle from edge k+1.
- wrap[i] is high in the last LED cycle of each period, one cycle before LED starts the next period. It never asserts in OFF/ON or at P = 0.
- PWM: LED lags fc by one cycle. Changing duty takes effect on the next cycle, not at a frame boundary.
- sync at edge s: BLINK channels show the first high cycle at edge s+1.
- Reset deassertion: first counting edge is the first clk rise with rst low.
- Reset mid-period: LED and wrap drop to 0 asynchronously; all config is lost.

## Test plan
- Reset: hold rst 5 cycles, then release with no writes -> LED = 0 and wrap = 0 for 1000 cycles. Assert rst between edges mid-blink -> LED drops to 0 before the next clk edge.
- BLINK ch0, P = 10 -> LED[0] pattern 5 high / 5 low starting 1 cycle after the write. wrap[0] high on the 10th cycle of each period. Other LED bits stay 0.
- BLINK ch3, P = 7 -> 4 high / 3 low. Rewrite P = 0 -> LED[3] = 0 and no wrap. Rewrite P = 1 -> LED[3] = 1 and wrap[3] high every cycle.
- PWM ch5, DUTY_W = 8: D = 64 -> 64 high / 192 low per 256 cycles, wrap[5] once per frame. D = 0 -> constant 0. D = 255 -> 255 high / 1 low.
- Phase alignment: ch1 BLINK P = 8, ch2 BLINK P = 8 written 3 cycles apart, then pulse sync -> LED[1] == LED[2] on every following cycle. sync plus a write to ch1 (P = 4) in the same cycle -> ch1 restarts at cnt 0 with P = 4.
- Out-of-range write: N_CH = 6, cfg_ch = 7, mode ON -> LED unchanged. Write ON to ch5 -> LED[5] = 1 one cycle later.
